// File: rtl/pe_stream_driver.sv
// pe_stream_driver: configures one PE, streams filter/ifmap/ipsum words from the local
// buffer to it and writes its opsum stream back. Optional cycle counter: PE_STREAM_DRIVER_PERF_EN.
module pe_stream_driver #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [11:0]       i_config,
  input  logic [ADDR_W-1:0] filter_base,
  input  logic [ADDR_W-1:0] ifmap_base,
  input  logic [ADDR_W-1:0] ipsum_base,
  input  logic [ADDR_W-1:0] opsum_base,
  output logic              busy,
  output logic              done,
  output logic              PE_en,
  output logic [11:0]       o_config,
  output logic [DATA_W-1:0] filter,
  output logic [DATA_W-1:0] ifmap,
  output logic [DATA_W-1:0] ipsum,
  output logic              filter_valid,
  output logic              ifmap_valid,
  output logic              ipsum_valid,
  input  logic              filter_ready,
  input  logic              ifmap_ready,
  input  logic              ipsum_ready,
  input  logic [DATA_W-1:0] opsum,
  input  logic              opsum_valid,
  output logic              opsum_ready,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data
`ifdef PE_STREAM_DRIVER_PERF_EN
  ,output logic [31:0]      perf_cycles
`endif
);

  typedef enum logic [2:0] {IDLE, CFG, LD_FILT, LD_IFMAP, LD_IPSUM, COLLECT, FIN} state_e;
  typedef enum logic [1:0] {E_RD, E_CAP, E_SEND} eng_e;

  state_e            state_q, state_d, next_ld;
  eng_e              eng_q, eng_d;
  logic [11:0]       cfg_q, cfg_d;
  logic [ADDR_W-1:0] fb_q, fb_d, ib_q, ib_d, pb_q, pb_d, ob_q, ob_d;
  logic [7:0]        cnt_q, cnt_d, ifa_q, ifa_d, col_q, col_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;

  logic [7:0]        p, rs, f, prs, colp, nwords, rd_off;
  logic [ADDR_W-1:0] rd_base, rd_addr;
  logic              sel_ready, rd_en, vld;

  assign p    = 8'(cfg_q[8:7]) + 8'd1;
  assign rs   = 8'(cfg_q[11:10]) + 8'd1;
  assign f    = 8'(cfg_q[6:2]);
  assign prs  = p * rs;
  assign colp = col_q * p;

  // Per-stream word count, address source and successor state of the send engine.
  always_comb begin
    nwords    = p;
    rd_base   = '0;
    rd_off    = '0;
    sel_ready = 1'b0;
    next_ld   = COLLECT;
    case (state_q)
      LD_FILT: begin
        nwords = prs; rd_base = fb_q; rd_off = cnt_q;
        sel_ready = filter_ready; next_ld = LD_IFMAP;
      end
      LD_IFMAP: begin
        nwords = (col_q == 8'd0) ? rs : 8'd1; rd_base = ib_q; rd_off = ifa_q;
        sel_ready = ifmap_ready; next_ld = LD_IPSUM;
      end
      LD_IPSUM: begin
        nwords = p; rd_base = pb_q; rd_off = colp + cnt_q;
        sel_ready = ipsum_ready; next_ld = COLLECT;
      end
      default: ;
    endcase
  end

  // A read issued in the handshake cycle fetches the following word, hence the +1.
  assign rd_addr = rd_base + ADDR_W'(rd_off) + {{(ADDR_W-1){1'b0}}, (eng_q == E_SEND)};

  always_comb begin
    state_d   = state_q;
    eng_d     = eng_q;
    cfg_d     = cfg_q;
    fb_d      = fb_q;
    ib_d      = ib_q;
    pb_d      = pb_q;
    ob_d      = ob_q;
    cnt_d     = cnt_q;
    ifa_d     = ifa_q;
    col_d     = col_q;
    hold_d    = hold_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    rd_en     = 1'b0;
    vld       = 1'b0;
    opsum_ready = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        cfg_d = i_config;
        fb_d  = filter_base;
        ib_d  = ifmap_base;
        pb_d  = ipsum_base;
        ob_d  = opsum_base;
        cnt_d = '0;
        ifa_d = '0;
        col_d = '0;
        eng_d = E_RD;
        state_d = CFG;
      end
      CFG: state_d = LD_FILT;
      LD_FILT, LD_IFMAP, LD_IPSUM: begin
        case (eng_q)
          E_RD: begin
            rd_en = 1'b1;
            eng_d = E_CAP;
          end
          E_CAP: begin
            hold_d = mem_rd_data;
            eng_d  = E_SEND;
          end
          default: begin
            vld = 1'b1;
            if (sel_ready) begin
              if (state_q == LD_IFMAP) ifa_d = ifa_q + 8'd1;
              if (cnt_q == nwords - 8'd1) begin
                cnt_d   = '0;
                eng_d   = E_RD;
                state_d = next_ld;
              end else begin
                rd_en = 1'b1;
                cnt_d = cnt_q + 8'd1;
                eng_d = E_CAP;
              end
            end
          end
        endcase
      end
      COLLECT: begin
        opsum_ready = 1'b1;
        if (opsum_valid) begin
          wr_en_d   = 1'b1;
          wr_addr_d = ob_q + ADDR_W'(colp + cnt_q);
          wr_data_d = opsum;
          if (cnt_q == p - 8'd1) begin
            cnt_d = '0;
            if (col_q == f) state_d = FIN;
            else begin
              col_d   = col_q + 8'd1;
              state_d = LD_IFMAP;
            end
          end else cnt_d = cnt_q + 8'd1;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      eng_q     <= E_RD;
      cfg_q     <= '0;
      fb_q      <= '0;
      ib_q      <= '0;
      pb_q      <= '0;
      ob_q      <= '0;
      cnt_q     <= '0;
      ifa_q     <= '0;
      col_q     <= '0;
      hold_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      eng_q     <= eng_d;
      cfg_q     <= cfg_d;
      fb_q      <= fb_d;
      ib_q      <= ib_d;
      pb_q      <= pb_d;
      ob_q      <= ob_d;
      cnt_q     <= cnt_d;
      ifa_q     <= ifa_d;
      col_q     <= col_d;
      hold_q    <= hold_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign busy         = (state_q != IDLE) && (state_q != FIN);
  assign done         = (state_q == FIN);
  assign PE_en        = (state_q == CFG);
  assign o_config     = cfg_q;
  assign filter       = hold_q;
  assign ifmap        = hold_q;
  assign ipsum        = hold_q;
  assign filter_valid = vld && (state_q == LD_FILT);
  assign ifmap_valid  = vld && (state_q == LD_IFMAP);
  assign ipsum_valid  = vld && (state_q == LD_IPSUM);
  assign mem_rd_en    = rd_en;
  assign mem_rd_addr  = rd_en ? rd_addr : '0;
  assign mem_wr_en    = wr_en_q;
  assign mem_wr_addr  = wr_addr_q;
  assign mem_wr_data  = wr_data_q;

`ifdef PE_STREAM_DRIVER_PERF_EN
  logic [31:0] perf_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                         perf_q <= '0;
    else if (state_q == IDLE && start) perf_q <= '0;
    else if (busy)                    perf_q <= perf_q + 32'd1;
  end
  assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_pe_stream_driver.sv
// Scoreboard bench for pe_stream_driver: buffer model, random backpressure, opsum source.
module tb_pe_stream_driver;

  logic        clk, rst, start;
  logic [11:0] i_config, o_config;
  logic [15:0] filter_base, ifmap_base, ipsum_base, opsum_base;
  logic        busy, done, PE_en;
  logic [31:0] filter, ifmap, ipsum, opsum, mem_rd_data, mem_wr_data;
  logic        filter_valid, ifmap_valid, ipsum_valid;
  logic        filter_ready, ifmap_ready, ipsum_ready;
  logic        opsum_valid, opsum_ready, mem_rd_en, mem_wr_en;
  logic [15:0] mem_rd_addr, mem_wr_addr;
`ifdef PE_STREAM_DRIVER_PERF_EN
  logic [31:0] perf_cycles;
`endif

  pe_stream_driver #(.ADDR_W(16), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .i_config(i_config),
    .filter_base(filter_base), .ifmap_base(ifmap_base),
    .ipsum_base(ipsum_base), .opsum_base(opsum_base),
    .busy(busy), .done(done), .PE_en(PE_en), .o_config(o_config),
    .filter(filter), .ifmap(ifmap), .ipsum(ipsum),
    .filter_valid(filter_valid), .ifmap_valid(ifmap_valid), .ipsum_valid(ipsum_valid),
    .filter_ready(filter_ready), .ifmap_ready(ifmap_ready), .ipsum_ready(ipsum_ready),
    .opsum(opsum), .opsum_valid(opsum_valid), .opsum_ready(opsum_ready),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data)
`ifdef PE_STREAM_DRIVER_PERF_EN
    , .perf_cycles(perf_cycles)
`endif
  );

  typedef struct packed { logic [1:0] sid; logic [15:0] addr; } sw_t;
  typedef struct packed { logic [15:0] addr; logic [31:0] data; } wr_t;

  sw_t exp_q[$];
  wr_t wr_q[$];
  int n_chk = 0, n_err = 0;
  int pct_f = 100, pct_i = 100, pct_p = 100;
  int filt_block = 0, filt_hs = 0, stall_cnt = 0;
  int op_k = 0, op_limit = 1 << 30, done_cnt = 0, busy_cyc = 0;
  bit block_arm = 0, prev_stall = 0;
  logic [1:0]  prev_sid;
  logic [31:0] prev_data;
  logic [15:0] ob_tb;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [15:0] a);
    return {a ^ 16'h5A5A, a};
  endfunction

  function automatic logic outs_or();
    return |{busy, done, PE_en, o_config, filter, ifmap, ipsum, filter_valid, ifmap_valid,
             ipsum_valid, opsum_ready, mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data
`ifdef PE_STREAM_DRIVER_PERF_EN
             , perf_cycles
`endif
             };
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Buffer model: data for an address is only valid the cycle after the read strobe.
  always @(posedge clk) mem_rd_data <= mem_rd_en ? memf(mem_rd_addr) : $urandom;

  always @(posedge clk) begin
    #1;
    filter_ready = (filt_block > 0) ? 1'b0 : ($urandom_range(99) < pct_f);
    if (filt_block > 0) filt_block--;
    ifmap_ready = ($urandom_range(99) < pct_i);
    ipsum_ready = ($urandom_range(99) < pct_p);
    opsum       = $urandom;
    opsum_valid = (op_k < op_limit);
  end

  always @(negedge clk) begin
    logic cv, cr;
    logic [1:0] sid;
    logic [31:0] dat;
    int nv;
    sw_t e;
    wr_t w;
    if (!rst) prev_stall = 0;
    else begin
      nv  = int'(filter_valid) + int'(ifmap_valid) + int'(ipsum_valid);
      cv  = (nv != 0);
      sid = filter_valid ? 2'd0 : ifmap_valid ? 2'd1 : 2'd2;
      dat = filter_valid ? filter : ifmap_valid ? ifmap : ipsum;
      cr  = filter_valid ? filter_ready : ifmap_valid ? ifmap_ready : ipsum_ready;
      if (cv) chk("one_valid", nv, 1);
      if (prev_stall) begin
        chk("hold_valid", {cv, sid}, {1'b1, prev_sid});
        chk("hold_data", dat, prev_data);
      end
      if (cv && !cr) begin
        chk("no_rd_in_stall", mem_rd_en, 0);
        if (sid == 2'd0) stall_cnt++;
      end
      if (cv && cr) begin
        if (exp_q.size() == 0) chk("extra_word", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("stream_id", sid, e.sid);
          chk("stream_data", dat, memf(e.addr));
        end
        if (sid == 2'd0) begin
          filt_hs++;
          if (block_arm && filt_hs == 2) begin filt_block = 10; block_arm = 0; end
        end
      end
      prev_stall = cv && !cr;
      prev_sid   = sid;
      prev_data  = dat;
      if (mem_wr_en) begin
        if (wr_q.size() == 0) chk("extra_write", 1, 0);
        else begin
          w = wr_q.pop_front();
          chk("wr_addr", mem_wr_addr, w.addr);
          chk("wr_data", mem_wr_data, w.data);
        end
      end
      if (opsum_valid && opsum_ready) begin
        w.addr = ob_tb + 16'(op_k);
        w.data = opsum;
        wr_q.push_back(w);
        op_k++;
      end
      if (done) done_cnt++;
      if (busy) busy_cyc++;
    end
  end

  task automatic start_job(input logic [11:0] cfg, input logic [15:0] fb, ib, pb, ob);
    int p, rs, nf, ia;
    sw_t e;
    p  = int'(cfg[8:7]) + 1;
    rs = int'(cfg[11:10]) + 1;
    nf = int'(cfg[6:2]);
    for (int i = 0; i < p * rs; i++) begin e.sid = 2'd0; e.addr = fb + 16'(i); exp_q.push_back(e); end
    ia = 0;
    for (int c = 0; c <= nf; c++) begin
      for (int i = 0; i < ((c == 0) ? rs : 1); i++) begin
        e.sid = 2'd1; e.addr = ib + 16'(ia); exp_q.push_back(e); ia++;
      end
      for (int j = 0; j < p; j++) begin e.sid = 2'd2; e.addr = pb + 16'(c * p + j); exp_q.push_back(e); end
    end
    ob_tb = ob; op_k = 0; done_cnt = 0; busy_cyc = 0; stall_cnt = 0; filt_hs = 0;
    @(posedge clk); #1;
    start = 1'b1; i_config = cfg;
    filter_base = fb; ifmap_base = ib; ipsum_base = pb; opsum_base = ob;
    @(posedge clk); #1;
    start = 1'b0; i_config = 12'($urandom);
    filter_base = 16'($urandom); ifmap_base = 16'($urandom);
    ipsum_base = 16'($urandom); opsum_base = 16'($urandom);
    @(negedge clk);
    chk("pe_en_pulse", PE_en, 1);
    chk("o_config", o_config, cfg);
    chk("busy_rise", busy, 1);
    @(negedge clk);
    chk("pe_en_once", PE_en, 0);
  endtask

  task automatic finish_job(input int nop, input int exp_busy);
    int cyc;
    logic [31:0] pv;
    cyc = 0;
    while (!done && cyc < 8000) begin @(negedge clk); cyc++; end
    chk("done_seen", done, 1);
    chk("busy_at_done", busy, 0);
    if (exp_busy >= 0) chk("busy_cycles", busy_cyc, exp_busy);
    pv = 0;
`ifdef PE_STREAM_DRIVER_PERF_EN
    chk("perf_cycles", perf_cycles, busy_cyc);
    pv = perf_cycles;
`endif
    repeat (4) @(negedge clk);
    chk("done_once", done_cnt, 1);
    chk("stream_left", exp_q.size(), 0);
    chk("write_left", wr_q.size(), 0);
    chk("opsum_count", op_k, nop);
`ifdef PE_STREAM_DRIVER_PERF_EN
    chk("perf_hold", perf_cycles, pv);
`endif
  endtask

  localparam logic [11:0] CFG_A = {2'd2, 1'b0, 2'd1, 5'd0,  2'd3}; // p=2 rs=3 F=0 q=4
  localparam logic [11:0] CFG_B = {2'd1, 1'b1, 2'd0, 5'd3,  2'd0}; // p=1 rs=2 F=3
  localparam logic [11:0] CFG_C = {2'd3, 1'b0, 2'd3, 5'd5,  2'd1}; // p=4 rs=4 F=5
  localparam logic [11:0] CFG_D = {2'd0, 1'b0, 2'd0, 5'd31, 2'd0}; // p=1 rs=1 F=31
  localparam logic [11:0] CFG_E = 12'd0;                            // p=1 rs=1 F=0

  initial begin
    int cyc;
    rst = 1'b0; start = 1'b0; i_config = '0;
    filter_base = '0; ifmap_base = '0; ipsum_base = '0; opsum_base = '0;
    repeat (3) begin
      @(posedge clk); #1;
      start = 1'($urandom); i_config = 12'($urandom);
      filter_base = 16'($urandom); ifmap_base = 16'($urandom);
      ipsum_base = 16'($urandom); opsum_base = 16'($urandom);
      pct_f = $urandom_range(100); pct_i = $urandom_range(100); pct_p = $urandom_range(100);
      @(negedge clk);
      chk("reset_outputs", outs_or(), 0);
    end
    @(posedge clk); #1;
    start = 1'b0; rst = 1'b1;
    pct_f = 100; pct_i = 100; pct_p = 100;

    start_job(CFG_A, 16'h0100, 16'h0200, 16'h0300, 16'h0400);
    finish_job(2, 28);

    block_arm = 1;
    start_job(CFG_A, 16'h1000, 16'h2000, 16'h3000, 16'h4000);
    finish_job(2, -1);
    chk("filter_stall_cycles", stall_cnt >= 9, 1);

    pct_i = 50;
    start_job(CFG_B, 16'h0010, 16'h0020, 16'h0030, 16'h0040);
    finish_job(4, -1);

    pct_f = 60; pct_i = 60; pct_p = 60;
    start_job(CFG_C, 16'h5000, 16'h6000, 16'h7000, 16'h8000);
    finish_job(24, -1);

    pct_f = 100; pct_i = 100; pct_p = 100;
    start_job(CFG_D, 16'hFFFF, 16'hFFF0, 16'hFFE8, 16'hFFF8);
    finish_job(32, -1);

    op_limit = 1;
    start_job(CFG_B, 16'h0A00, 16'h0B00, 16'h0C00, 16'h0D00);
    cyc = 0;
    while (!(opsum_ready && !opsum_valid) && cyc < 4000) begin @(negedge clk); cyc++; end
    chk("col1_collect_reached", opsum_ready && !opsum_valid, 1);
    chk("col0_opsum_taken", op_k, 1);
    #2 rst = 1'b0;
    #1 chk("abort_outputs", outs_or(), 0);
    repeat (3) begin
      @(negedge clk);
      chk("abort_hold", outs_or(), 0);
    end
    chk("abort_no_done", done_cnt, 0);
    exp_q.delete();
    wr_q.delete();
    op_limit = 1 << 30;
    @(posedge clk); #1 rst = 1'b1;
    start_job(CFG_B, 16'h0A00, 16'h0B00, 16'h0C00, 16'h0D00);
    finish_job(4, -1);

    start_job(CFG_E, 16'h0001, 16'h0002, 16'h0003, 16'h0004);
    finish_job(1, 11);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pe_stream_driver.md
Name: pe_stream_driver

Overview:
- Initiator/transmitter on the other end of the PE's valid/ready streams.
- Configures one PE, then fetches packed filter, ifmap and ipsum words from a synchronous local buffer and pushes them to the PE in the order the PE consumes them.
- Accepts the opsum stream and writes it back to the buffer.
- Sits between the global-buffer read/write port and a single PE; the PE-array controller drives its `start`.

Parameters:
- ADDR_W, 16, word address width of the buffer port.
- DATA_W, 32, stream and buffer word width; each word packs four 8-bit lanes.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begin a job; sampled in IDLE only.
- i_config  in  12  [11:10]=rs-1, [9]=mode, [8:7]=p-1, [6:2]=F, [1:0]=q-1.
- filter_base / ifmap_base / ipsum_base / opsum_base  in  ADDR_W each  region base word addresses.
- busy  out  1  high from the cycle after an accepted `start` until `done`.
- done  out  1  one-cycle pulse when the job completes.
- PE_en  out  1  one-cycle config strobe to the PE.
- o_config  out  12  registered copy of `i_config`.
- filter / ifmap / ipsum  out  DATA_W each  stream data.
- filter_valid / ifmap_valid / ipsum_valid  out  1 each.
- filter_ready / ifmap_ready / ipsum_ready  in  1 each.
- opsum  in  DATA_W.
- opsum_valid  in  1.
- opsum_ready  out  1.
- mem_rd_en  out  1.
- mem_rd_addr  out  ADDR_W.
- mem_rd_data  in  DATA_W; valid the cycle after `mem_rd_en`.
- mem_wr_en / mem_wr_addr / mem_wr_data  out  1 / ADDR_W / DATA_W.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. Every output is 0, including `o_config`, all valids, `opsum_ready` and the mem strobes. All counters are cleared.
- Derived values: p=cfg[8:7]+1, rs=cfg[11:10]+1, F=cfg[6:2]. Column count is F+1. All counts are unsigned and fit in 8 bits.
- FSM states: IDLE, CFG, LD_FILT, LD_IFMAP, LD_IPSUM, COLLECT, FIN.
  - IDLE: `start`=1 latches config and bases, goes to CFG. `start` in any other state is ignored.
  - CFG: `PE_en`=1 for exactly one cycle with `o_config` valid, then LD_FILT.
  - LD_FILT: send p*rs words from filter_base+0.., then LD_IFMAP.
  - LD_IFMAP: column 0 sends rs words; later columns send 1 word. The ifmap address is one running counter from ifmap_base, so rs+F words are sent in total. Then LD_IPSUM.
  - LD_IPSUM: send p words from ipsum_base + col*p + j, then COLLECT.
  - COLLECT: `opsum_ready`=1. Accept p words. Word j of column col is written to opsum_base + col*p + j. After the p-th handshake: if col==F go to FIN, else col+1 and go to LD_IFMAP.
  - FIN: `done`=1 for one cycle, `busy` drops in the same cycle, then IDLE.
- Send engine (shared by the three LD states), with a one-entry holding register per word:
  - Cycle 0: `mem_rd_en`=1 with the address.
  - Cycle 1: `mem_rd_data` is captured.
  - Cycle 2 onward: the stream's valid is high; data is held stable until ready=1.
  - A handshake retires the word. The next read issues in the same handshake cycle, so steady state is 2 cycles/word when ready is held high.
  - Valid never drops without a handshake.
  - Only the valid of the current state's stream may be high.
- Write path: an opsum handshake registers `mem_wr_en`=1, address and data in the next cycle. The write port never stalls.
- Boundaries:
  - p=1, rs=1, F=0 gives 1 filter word, 1 ifmap word, 1 ipsum word and 1 opsum word, then `done`.
  - F=31 runs 32 columns.
  - Address arithmetic wraps modulo 2^ADDR_W.
  - Reset mid-job aborts immediately with no `done`.
  - `opsum_valid` outside COLLECT is ignored; `opsum_ready` is 0 there.

Optional Feature:
- Macro: PE_STREAM_DRIVER_PERF_EN.
- When defined: adds output `perf_cycles` (32 bits). It clears on an accepted `start` and increments every cycle while `busy`=1. It holds its value after `done` until the next `start`. Reset value is 0.
- When undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
1. rst=0 for 3 cycles with random inputs -> all outputs 0 and state IDLE. Release, start=1 with cfg p=2, rs=3, F=0, q=4 -> `PE_en` pulses once 1 cycle after start, and `o_config` equals `i_config`.
2. Same cfg, buffer words = address, ready held 1 -> filter addresses base..base+5 (6 words), ifmap base..base+2, ipsum base..base+1. Two opsum accepted and written to opsum_base+0/+1. `done` pulses once.
3. p=1, rs=2, F=3, ifmap_ready toggled randomly -> ifmap sends exactly 5 words. Data and valid stay stable while ready=0. opsum written to opsum_base+0..3 in column order.
4. Backpressure: filter_ready=0 for 10 cycles mid-stream -> `filter_valid` stays 1 with unchanged data and no further `mem_rd_en` until the handshake.
5. rst asserted during COLLECT of column 1 -> outputs 0 immediately and no `done`. A new start afterwards completes normally.
6. PE_STREAM_DRIVER_PERF_EN defined, p=1, rs=1, F=0, all ready=1, opsum returned 1 cycle after ipsum -> `perf_cycles` equals the measured busy-cycle count and stays constant after `done`.
